timer_control: RTL

- Upstream controller for the microwave countdown chain: minutes digit counter, mod-6 seconds-tens counter, mod-10 seconds-ones counter.
- Captures BCD keypad entry into three load digits (M:TS) and pulses `loadn` to load the counters.
- Generates the prescaled count-enable tick and consumes the chain's `zero` flag.
- Sequences IDLE/LOAD/RUN/PAUSE/DONE and drives the magnetron enable and the done indication.

---
 rtl/timer_control_if.sv | 26 ++
 rtl/timer_control.sv | 133 +++++++++++++
 2 files changed

// File: rtl/timer_control_if.sv
// rtl/timer_control_if.sv - keypad, control and counter-chain signals of the microwave timer controller
interface timer_control_if;
  logic       key_valid;
  logic [3:0] key;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic       zero;
  logic [3:0] data_min;
  logic [3:0] data_tens;
  logic [3:0] data_ones;
  logic       loadn;
  logic       en;
  logic       mag_on;
  logic       done;

  modport master (
    output key_valid, key, startn, stopn, door_closed, zero,
    input  data_min, data_tens, data_ones, loadn, en, mag_on, done
  );

  modport slave (
    input  key_valid, key, startn, stopn, door_closed, zero,
    output data_min, data_tens, data_ones, loadn, en, mag_on, done
  );
endinterface

// File: rtl/timer_control.sv
// rtl/timer_control.sv - keypad capture, count-tick prescaler and cook sequencer for the countdown chain
module timer_control #(
  parameter int TICK_DIV    = 100,
  parameter int DONE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             clearn,
  timer_control_if.slave   bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   done_cnt_q, done_cnt_d;
  logic            loadn_q, loadn_d, en_q, en_d, mag_on_q, mag_on_d, done_q, done_d;
  logic            key_ok, digits_nz;

  // A key shifts the ones digit into tens, so it is only legal while ones <= 5.
  assign key_ok    = bus.key_valid && (bus.key <= 4'd9) && (ones_q <= 4'd5);
  assign digits_nz = |{min_q, tens_q, ones_q};

  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    presc_d    = presc_q;
    done_cnt_d = done_cnt_q;
    en_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.stopn) begin
          min_d  = 4'd0;
          tens_d = 4'd0;
          ones_d = 4'd0;
        end else begin
          if (key_ok) begin
            min_d  = tens_q;
            tens_d = ones_q;
            ones_d = bus.key;
          end
          if (!bus.startn && bus.door_closed && digits_nz) begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        presc_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // zero seen while a tick is still being absorbed by the chain is not trusted yet
        if (!bus.stopn) begin
          state_d = ST_PAUSE;
        end else if (bus.zero && !en_q) begin
          state_d    = ST_DONE;
          done_cnt_d = '0;
        end else if (!bus.door_closed) begin
          state_d = ST_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          en_d    = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (!bus.stopn) begin
          state_d = ST_IDLE;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
        end else if (!bus.startn && bus.door_closed) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.key_valid || !bus.stopn || (done_cnt_q == DONE_LAST)) begin
          state_d = ST_IDLE;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
        end else begin
          done_cnt_d = done_cnt_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    loadn_d  = (state_d != ST_LOAD);
    mag_on_d = (state_d == ST_RUN);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q    <= ST_IDLE;
      min_q      <= 4'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      presc_q    <= '0;
      done_cnt_q <= '0;
      loadn_q    <= 1'b1;
      en_q       <= 1'b0;
      mag_on_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      presc_q    <= presc_d;
      done_cnt_q <= done_cnt_d;
      loadn_q    <= loadn_d;
      en_q       <= en_d;
      mag_on_q   <= mag_on_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_min  = min_q;
  assign bus.data_tens = tens_q;
  assign bus.data_ones = ones_q;
  assign bus.loadn     = loadn_q;
  assign bus.en        = en_q;
  assign bus.mag_on    = mag_on_q;
  assign bus.done      = done_q;
endmodule
